// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_pkg
// Description : Shared definitions for the multi-product vending machine:
//               FSM state encodings, the price step and the price function.
//               Optional feature macro used by this block: VM_RESTOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

  localparam int          c_ST_W      = 3;
  localparam logic [2:0]  c_ST_IDLE     = 3'd0;
  localparam logic [2:0]  c_ST_SELECT   = 3'd1;
  localparam logic [2:0]  c_ST_PAY      = 3'd2;
  localparam logic [2:0]  c_ST_DISPENSE = 3'd3;
  localparam logic [2:0]  c_ST_CHANGE   = 3'd4;
  localparam logic [2:0]  c_ST_REFUND   = 3'd5;

  // Each product costs one step more than the previous one.
  localparam int unsigned c_PRICE_STEP = 10;

  // Full-width price; callers truncate to their value width.
  function automatic int unsigned vm_price(input int unsigned code);
    return c_PRICE_STEP * (code + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_inventory.sv
`default_nettype none
// ============================================================================
// Module      : vm_inventory
// Description : Per-product stock counters. Reports whether the selected
//               product is unavailable, decrements a slot on dispense and,
//               when VM_RESTOCK_EN is defined, applies saturating restocks.
// Ports       : clk, rst          - clock, async active-high reset
//               i_sel_code        - product being queried
//               o_stock_zero      - selected product invalid or out of stock
//               i_dec_en/code     - decrement one unit of a product
//               i_restock_en/code/qty (VM_RESTOCK_EN only) - add stock
// Revision    : 1.0 - initial release
// ============================================================================
module vm_inventory
  import vm_pkg::*;
#(
  parameter int NUM_PRODUCTS = 8,
  parameter int CODE_W       = 3,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] i_sel_code,
  output logic              o_stock_zero,
  input  logic              i_dec_en,
  input  logic [CODE_W-1:0] i_dec_code
`ifdef VM_RESTOCK_EN
  ,
  input  logic               i_restock_en,
  input  logic [CODE_W-1:0]  i_restock_code,
  input  logic [STOCK_W-1:0] i_restock_qty
`endif
);

  logic [STOCK_W-1:0] r_stock [NUM_PRODUCTS];
  logic [STOCK_W-1:0] w_sel_stock;
  logic               w_sel_valid;

  // Decoded read: codes with no matching slot read as invalid.
  always_comb begin
    w_sel_stock = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (i_sel_code == CODE_W'(i)) begin
        w_sel_stock = r_stock[i];
        w_sel_valid = 1'b1;
      end
    end
  end

  assign o_stock_zero = !w_sel_valid || (w_sel_stock == '0);

`ifdef VM_RESTOCK_EN
  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
  endfunction
`endif

  // Dispense and restock never coincide (restock is IDLE-only), so the
  // decrement simply takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        r_stock[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        if (i_dec_en && (i_dec_code == CODE_W'(i))) begin
          if (r_stock[i] != '0) begin
            r_stock[i] <= r_stock[i] - STOCK_W'(1);
          end
        end
`ifdef VM_RESTOCK_EN
        else if (i_restock_en && (i_restock_code == CODE_W'(i))) begin
          r_stock[i] <= sat_add(r_stock[i], i_restock_qty);
        end
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_multi
// Description : Multi-product vending controller. Captures a selection,
//               collects coins (one per cycle) or an online confirmation,
//               dispenses, returns change, and refunds on cancel/timeout.
//               Optional feature: define VM_RESTOCK_EN to add restock ports.
// Ports       : clk, rst                     - clock, async active-high reset
//               i_start, i_product_code      - begin transaction / selection
//               i_coin_valid, i_coin_value   - coin strobe and value
//               i_online_payment, i_cancel   - external payment / abort
//               o_state, o_product_price, o_credit - status
//               o_dispense_product, o_dispense_code - dispenser pulse
//               o_return_change, o_change_valid     - change actuator pulse
//               o_coin_reject, o_sold_out           - rejection pulses
//               i_restock_* (VM_RESTOCK_EN only)    - stock replenishment
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int NUM_PRODUCTS   = 8,
  parameter int CODE_W         = 3,
  parameter int VALUE_W        = 8,
  parameter int STOCK_W        = 4,
  parameter int INIT_STOCK     = 5,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [CODE_W-1:0]  i_product_code,
  input  logic               i_coin_valid,
  input  logic [VALUE_W-1:0] i_coin_value,
  input  logic               i_online_payment,
  input  logic               i_cancel,
`ifdef VM_RESTOCK_EN
  input  logic               i_restock_valid,
  input  logic [CODE_W-1:0]  i_restock_code,
  input  logic [STOCK_W-1:0] i_restock_qty,
`endif
  output logic [2:0]         o_state,
  output logic [VALUE_W-1:0] o_product_price,
  output logic [VALUE_W-1:0] o_credit,
  output logic               o_dispense_product,
  output logic [CODE_W-1:0]  o_dispense_code,
  output logic [VALUE_W-1:0] o_return_change,
  output logic               o_change_valid,
  output logic               o_coin_reject,
  output logic               o_sold_out
);

  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_ST_W-1:0]  r_state;
  logic [c_ST_W-1:0]  w_state_nxt;
  logic [CODE_W-1:0]  r_code;
  logic [VALUE_W-1:0] r_price;
  logic [VALUE_W-1:0] r_credit;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_online;

  logic               w_stock_zero;
  logic               w_sel_bad;
  logic [VALUE_W-1:0] w_price;
  logic               w_paid;
  logic               w_leave;
  logic [VALUE_W:0]   w_coin_sum;
  logic               w_coin_ovf;
  logic               w_coin_accept;
  logic               w_timeout;
  logic [VALUE_W-1:0] w_change_amt;
  logic               w_dec_en;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  assign w_price    = VALUE_W'(vm_price(32'(r_code)));
  assign w_sel_bad  = (32'(r_code) >= 32'(NUM_PRODUCTS)) || w_stock_zero;
  assign w_paid     = (r_credit >= r_price);
  // Any condition that ends PAY this cycle; a coin arriving in that cycle
  // would otherwise be silently swallowed, so it is refused instead.
  assign w_leave    = i_cancel || i_online_payment || w_paid;
  assign w_coin_sum = {1'b0, r_credit} + {1'b0, i_coin_value};
  assign w_coin_ovf = w_coin_sum[VALUE_W];
  assign w_coin_accept = (r_state == c_ST_PAY) && i_coin_valid &&
                         !w_leave && !w_coin_ovf;
  assign w_timeout  = (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1)) && !w_coin_accept;
  // Online payment covers the price, so all coin credit goes back.
  assign w_change_amt = r_online ? r_credit : (r_credit - r_price);
  assign w_dec_en   = (r_state == c_ST_DISPENSE);

  // --------------------------------------------------------------------------
  // Inventory
  // --------------------------------------------------------------------------
`ifdef VM_RESTOCK_EN
  logic w_restock_en;
  assign w_restock_en = i_restock_valid && (r_state == c_ST_IDLE);
`endif

  vm_inventory #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .CODE_W       (CODE_W),
    .STOCK_W      (STOCK_W),
    .INIT_STOCK   (INIT_STOCK)
  ) u_inv (
    .clk            (clk),
    .rst            (rst),
    .i_sel_code     (r_code),
    .o_stock_zero   (w_stock_zero),
    .i_dec_en       (w_dec_en),
    .i_dec_code     (r_code)
`ifdef VM_RESTOCK_EN
    ,
    .i_restock_en   (w_restock_en),
    .i_restock_code (i_restock_code),
    .i_restock_qty  (i_restock_qty)
`endif
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = c_ST_SELECT;
        end
      end
      c_ST_SELECT: begin
        w_state_nxt = w_sel_bad ? c_ST_IDLE : c_ST_PAY;
      end
      c_ST_PAY: begin
        if (i_cancel) begin
          w_state_nxt = c_ST_REFUND;
        end else if (i_online_payment || w_paid) begin
          w_state_nxt = c_ST_DISPENSE;
        end else if (w_timeout) begin
          w_state_nxt = c_ST_REFUND;
        end
      end
      c_ST_DISPENSE: w_state_nxt = c_ST_CHANGE;
      c_ST_CHANGE:   w_state_nxt = c_ST_IDLE;
      c_ST_REFUND:   w_state_nxt = c_ST_IDLE;
      default:       w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction registers: selection, price, credit, idle timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code   <= '0;
      r_price  <= '0;
      r_credit <= '0;
      r_timer  <= '0;
      r_online <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (i_start) begin
            r_code <= i_product_code;
          end
        end
        c_ST_SELECT: begin
          if (!w_sel_bad) begin
            r_price <= w_price;
          end
          r_timer  <= '0;
          r_online <= 1'b0;
        end
        c_ST_PAY: begin
          if (w_coin_accept) begin
            r_credit <= w_coin_sum[VALUE_W-1:0];
            r_timer  <= '0;
          end else begin
            r_timer  <= r_timer + c_TMR_W'(1);
          end
          if (!i_cancel && i_online_payment) begin
            r_online <= 1'b1;
          end
        end
        c_ST_CHANGE, c_ST_REFUND: begin
          r_credit <= '0;
          r_price  <= '0;
          r_online <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_dispense_product = 1'b0;
    o_dispense_code    = '0;
    o_return_change    = '0;
    o_change_valid     = 1'b0;
    o_sold_out         = 1'b0;
    // Refusal is immediate so the acceptor can eject the coin this cycle.
    o_coin_reject      = !rst && i_coin_valid && !w_coin_accept;
    case (r_state)
      c_ST_SELECT: o_sold_out = w_sel_bad;
      c_ST_DISPENSE: begin
        o_dispense_product = 1'b1;
        o_dispense_code    = r_code;
      end
      c_ST_CHANGE: begin
        o_return_change = w_change_amt;
        o_change_valid  = (w_change_amt != '0);
      end
      c_ST_REFUND: begin
        o_return_change = r_credit;
        o_change_valid  = (r_credit != '0);
      end
      default: ;
    endcase
  end

  assign o_state         = r_state;
  assign o_product_price = r_price;
  assign o_credit        = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_machine_multi
// Description : Self-checking bench for vending_machine_multi. Directed
//               scenarios plus randomized transactions are scored against a
//               transaction-level model of prices, credit and stock.
//               Builds with or without VM_RESTOCK_EN (restock tied off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;

  localparam int NP   = 8;
  localparam int CW   = 3;
  localparam int VW   = 8;
  localparam int SW   = 4;
  localparam int INIT = 5;
  localparam int TO   = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] product_code = '0;
  logic          coin_valid = 1'b0;
  logic [VW-1:0] coin_value = '0;
  logic          online_payment = 1'b0;
  logic          cancel = 1'b0;
  logic [2:0]    o_state;
  logic [VW-1:0] o_product_price;
  logic [VW-1:0] o_credit;
  logic          o_dispense_product;
  logic [CW-1:0] o_dispense_code;
  logic [VW-1:0] o_return_change;
  logic          o_change_valid;
  logic          o_coin_reject;
  logic          o_sold_out;

  always #5 clk = ~clk;

  vending_machine_multi #(
    .NUM_PRODUCTS(NP), .CODE_W(CW), .VALUE_W(VW), .STOCK_W(SW),
    .INIT_STOCK(INIT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (start),
    .i_product_code     (product_code),
    .i_coin_valid       (coin_valid),
    .i_coin_value       (coin_value),
    .i_online_payment   (online_payment),
    .i_cancel           (cancel),
`ifdef VM_RESTOCK_EN
    .i_restock_valid    (1'b0),
    .i_restock_code     ({CW{1'b0}}),
    .i_restock_qty      ({SW{1'b0}}),
`endif
    .o_state            (o_state),
    .o_product_price    (o_product_price),
    .o_credit           (o_credit),
    .o_dispense_product (o_dispense_product),
    .o_dispense_code    (o_dispense_code),
    .o_return_change    (o_return_change),
    .o_change_valid     (o_change_valid),
    .o_coin_reject      (o_coin_reject),
    .o_sold_out         (o_sold_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stock_m [NP];
  int cq [$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int ev_disp, ev_disp_code, ev_chg, ev_chg_amt, ev_rej, ev_sold, ev_price;
  int ev_pay_cyc, ev_chg_cyc;

  task automatic clear_events();
    ev_disp = 0; ev_disp_code = -1; ev_chg = 0; ev_chg_amt = -1;
    ev_rej = 0; ev_sold = 0; ev_price = -1; ev_pay_cyc = -1; ev_chg_cyc = -1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (o_dispense_product) begin ev_disp++; ev_disp_code = int'(o_dispense_code); end
      if (o_change_valid) begin
        ev_chg++; ev_chg_amt = int'(o_return_change); ev_chg_cyc = cyc;
      end
      if (o_coin_reject) ev_rej++;
      if (o_sold_out) ev_sold++;
      if (o_state == 3'd2) begin
        ev_price = int'(o_product_price);
        if (ev_pay_cyc < 0) ev_pay_cyc = cyc;
      end
    end
  end

  task automatic coins3(input int n, input int a, input int b, input int c);
    cq.delete();
    if (n > 0) cq.push_back(a);
    if (n > 1) cq.push_back(b);
    if (n > 2) cq.push_back(c);
  endtask

  // ending: 0 = nothing (pay or time out), 1 = online payment, 2 = cancel,
  // asserted the cycle after the last coin.
  task automatic run_txn(input int code, input int ending);
    int price, credit, paid_idx, n, amt, wait_n;
    int exp_rej, exp_disp, exp_cv, exp_sold;
    price = 10 * (code + 1);
    credit = 0; paid_idx = -1; n = cq.size();
    exp_rej = 0; exp_disp = 0; exp_cv = 0; exp_sold = 0; amt = 0;
    if (stock_m[code] == 0) begin
      exp_sold = 1;
      exp_rej  = n;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (credit >= price)                exp_rej++;
        else if (credit + cq[i] > 255)      exp_rej++;
        else begin
          credit += cq[i];
          if (credit >= price) paid_idx = i;
        end
      end
      if (paid_idx >= 0 && paid_idx < n - 1) begin
        exp_disp = 1; amt = credit - price;
      end else if (ending == 2) begin
        amt = credit;
      end else if (ending == 1) begin
        exp_disp = 1; amt = credit;
      end else if (credit >= price) begin
        exp_disp = 1; amt = credit - price;
      end else begin
        amt = credit;
      end
      exp_cv = (amt > 0) ? 1 : 0;
      if (exp_disp == 1) stock_m[code]--;
    end

    clear_events();
    start = 1'b1; product_code = CW'(code);
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      coin_valid = 1'b1; coin_value = VW'(cq[i]);
      tick();
    end
    coin_valid = 1'b0;
    if (ending != 0) begin
      online_payment = (ending == 1);
      cancel         = (ending == 2);
      tick();
      online_payment = 1'b0;
      cancel         = 1'b0;
    end
    wait_n = 0;
    while (o_state != 3'd0 && wait_n < 400) begin
      tick();
      wait_n++;
    end
    check("return_to_idle", (wait_n < 400) ? 1 : 0, 1);
    tick();

    check("dispense_cnt", ev_disp, exp_disp);
    if (exp_disp == 1) check("dispense_code", ev_disp_code, code);
    check("change_cnt", ev_chg, exp_cv);
    if (exp_cv == 1) check("change_amt", ev_chg_amt, amt);
    check("coin_reject_cnt", ev_rej, exp_rej);
    check("sold_out_cnt", ev_sold, exp_sold);
    if (exp_sold == 0) check("price", ev_price, price);
    check("stock", int'(dut.u_inv.r_stock[code]), stock_m[code]);
    check("credit_cleared", int'(o_credit), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals [6] = '{5, 10, 20, 50, 100, 250};
    for (int i = 0; i < NP; i++) stock_m[i] = INIT;
    clear_events();

    // Reset state
    repeat (3) tick();
    check("rst_state", int'(o_state), 0);
    check("rst_credit", int'(o_credit), 0);
    check("rst_price", int'(o_product_price), 0);
    check("rst_pulses", int'({o_dispense_product, o_change_valid, o_coin_reject, o_sold_out}), 0);
    check("rst_disp_code", int'(o_dispense_code), 0);
    check("rst_change", int'(o_return_change), 0);
    for (int i = 0; i < NP; i++) check("rst_stock", int'(dut.u_inv.r_stock[i]), INIT);
    rst = 1'b0;
    tick();

    // Exact payment, no change
    coins3(2, 10, 10, 0);  run_txn(1, 0);
    // Payment complete on first coin; the next coin is refused
    coins3(2, 50, 20, 0);  run_txn(4, 0);
    // Overpayment returns change
    coins3(3, 20, 20, 20); run_txn(4, 0);
    // Online payment with coin credit pending: credit returned in full
    coins3(1, 10, 0, 0);   run_txn(0, 1);
    // Cancel refunds credit, stock untouched
    coins3(1, 10, 0, 0);   run_txn(2, 2);
    // Drain product 3, then one more is sold out
    for (int k = 0; k < INIT; k++) begin
      coins3(3, 20, 10, 10); run_txn(3, 0);
    end
    coins3(1, 10, 0, 0);   run_txn(3, 0);
    // Overflowing coin is refused
    coins3(3, 10, 250, 50); run_txn(7, 2);
    // Inactivity timeout refunds credit after TO idle cycles
    coins3(1, 20, 0, 0);   run_txn(5, 0);
    check("timeout_latency", ev_chg_cyc - ev_pay_cyc, TO + 1);

    // Asynchronous reset in the middle of PAY
    clear_events();
    start = 1'b1; product_code = CW'(6);
    tick();
    start = 1'b0;
    tick();
    coin_valid = 1'b1; coin_value = VW'(20);
    tick();
    coin_valid = 1'b0;
    check("mid_pay_credit", int'(o_credit), 20);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(o_state), 0);
    check("arst_credit", int'(o_credit), 0);
    check("arst_price", int'(o_product_price), 0);
    check("arst_pulses", int'({o_dispense_product, o_change_valid, o_coin_reject, o_sold_out}), 0);
    for (int i = 0; i < NP; i++) begin
      stock_m[i] = INIT;
      check("arst_stock", int'(dut.u_inv.r_stock[i]), INIT);
    end
    tick();
    rst = 1'b0;
    tick();

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      int nc, code, ending;
      nc = int'($urandom_range(0, 4));
      code = int'($urandom_range(0, NP - 1));
      ending = int'($urandom_range(0, 2));
      cq.delete();
      for (int j = 0; j < nc; j++) cq.push_back(vals[$urandom_range(0, 5)]);
      run_txn(code, ending);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
